// File: rtl/euler_result_printer.sv
// Euler result printer: captures a solver result, converts it to decimal with a
// sequential double-dabble, then streams the digits (leading zeros suppressed)
// followed by a terminator byte over a valid/ready byte interface.
module euler_result_printer #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DIGITS     = 20,
  parameter logic [7:0]  TERMINATOR = 8'h0A
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_results_valid,
  input  logic [WIDTH-1:0] i_results,
  output logic             o_char_valid,
  output logic [7:0]       o_char_data,
  input  logic             i_char_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StSkip,
    StEmit,
    StTerm,
    StDone
  } state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_bin;
  logic [BcdW-1:0]   r_bcd;
  logic [CntW-1:0]   r_cnt;
  logic [IdxW-1:0]   r_idx;

  state_e            w_state_d;
  logic [WIDTH-1:0]  w_bin_d;
  logic [BcdW-1:0]   w_bcd_d;
  logic [CntW-1:0]   w_cnt_d;
  logic [IdxW-1:0]   w_idx_d;

  logic [BcdW-1:0]   w_bcd_adj;
  logic [3:0]        w_cur_digit;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Select the BCD digit addressed by the emit/skip index.
  always_comb begin
    w_cur_digit = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IdxW'(i) == r_idx) begin
        w_cur_digit = r_bcd[4*i +: 4];
      end
    end
  end

  // Next-state and output decode; outputs depend on state only, never on ready.
  always_comb begin
    w_state_d    = r_state;
    w_bin_d      = r_bin;
    w_bcd_d      = r_bcd;
    w_cnt_d      = r_cnt;
    w_idx_d      = r_idx;
    o_char_valid = 1'b0;
    o_char_data  = 8'h00;
    o_done       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_results_valid) begin
          w_bin_d   = i_results;
          w_bcd_d   = '0;
          w_cnt_d   = '0;
          w_idx_d   = '0;
          w_state_d = StConvert;
        end
      end

      StConvert: begin
        {w_bcd_d, w_bin_d} = {w_bcd_adj, r_bin} << 1;
        w_cnt_d = r_cnt + 1'b1;
        if (r_cnt == CntW'(WIDTH - 1)) begin
          w_idx_d   = IdxW'(DIGITS - 1);
          w_state_d = StSkip;
        end
      end

      // Walk down past leading zeros; digit 0 is always printed.
      StSkip: begin
        if ((w_cur_digit == 4'h0) && (r_idx != '0)) begin
          w_idx_d = r_idx - 1'b1;
        end else begin
          w_state_d = StEmit;
        end
      end

      StEmit: begin
        o_char_valid = 1'b1;
        o_char_data  = 8'h30 + {4'h0, w_cur_digit};
        if (i_char_ready) begin
          if (r_idx == '0) begin
            w_state_d = StTerm;
          end else begin
            w_idx_d = r_idx - 1'b1;
          end
        end
      end

      StTerm: begin
        o_char_valid = 1'b1;
        o_char_data  = TERMINATOR;
        if (i_char_ready) begin
          w_state_d = StDone;
        end
      end

      StDone: begin
        o_done    = 1'b1;
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_busy = (r_state != StIdle);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_bin   <= w_bin_d;
      r_bcd   <= w_bcd_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
    end
  end

endmodule

// File: tb/tb_euler_result_printer.sv
// Bench for euler_result_printer: directed and random results, random sink
// backpressure, reference decimal strings built with div/mod by ten.
module tb_euler_result_printer;

  logic        clk;
  logic        i_reset;
  logic        i_results_valid;
  logic [63:0] i_results;
  logic        o_char_valid;
  logic [7:0]  o_char_data;
  logic        i_char_ready;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_errors = 0;

  euler_result_printer dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_results_valid (i_results_valid),
    .i_results       (i_results),
    .o_char_valid    (o_char_valid),
    .o_char_data     (o_char_data),
    .i_char_ready    (i_char_ready),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) else begin
      n_errors++;
      $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, obs, exp);
    end
  endtask

  // Reference: unsigned decimal text of v, no leading zeros.
  function automatic string dec_str(input logic [63:0] v);
    string       s;
    logic [63:0] t;
    byte         c;
    s = "";
    t = v;
    if (t == 64'd0) return "0";
    while (t != 64'd0) begin
      c = byte'(64'd48 + (t % 64'd10));
      s = {$sformatf("%c", c), s};
      t = t / 64'd10;
    end
    return s;
  endfunction

  // Capture val, drain the byte stream with ready high ready_pct percent of
  // the time, and compare text, first-byte timing and busy/done behaviour.
  task automatic run_case(input logic [63:0] val, input int ready_pct, input bit noise);
    string      exp_s;
    string      got_s;
    int         e;
    int         first_e;
    int         done_e;
    int         n_done;
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    bit         fin;
    exp_s   = {dec_str(val), "\n"};
    got_s   = "";
    first_e = -1;
    done_e  = -1;
    n_done  = 0;
    pv      = 1'b0;
    pr      = 1'b0;
    pd      = 8'h00;
    fin     = 1'b0;

    @(negedge clk);
    i_results       = val;
    i_results_valid = 1'b1;
    @(negedge clk);
    i_results_valid = 1'b0;
    i_results       = '0;
    check("busy_after_capture", 64'(o_busy), 64'd1);

    e = 0;
    while (!fin && e < 800) begin
      if (pv && !pr) begin
        check("hold_valid", 64'(o_char_valid), 64'd1);
        check("hold_data", 64'(o_char_data), 64'(pd));
      end
      if (o_char_valid && first_e < 0) first_e = e;
      if (o_done) begin
        n_done++;
        if (done_e < 0) begin
          done_e = e;
          check("busy_with_done", 64'(o_busy), 64'd1);
        end
      end else if (done_e >= 0) begin
        check("busy_after_done", 64'(o_busy), 64'd0);
        fin = 1'b1;
      end
      i_char_ready = (int'($urandom_range(99)) < ready_pct);
      if (noise) begin
        i_results_valid = (e >= 5 && e <= 10);
        i_results       = 64'd7;
      end
      if (o_char_valid && i_char_ready) got_s = {got_s, $sformatf("%c", o_char_data)};
      pv = o_char_valid;
      pr = i_char_ready;
      pd = o_char_data;
      @(negedge clk);
      e++;
    end
    i_results_valid = 1'b0;

    check("finished", 64'(fin), 64'd1);
    check_str("bytes", got_s, exp_s);
    check("first_valid_edge", 64'(first_e), 64'(65 + 20 - (exp_s.len() - 1)));
    check("done_pulses", 64'(n_done), 64'd1);
    if (ready_pct == 100) begin
      check("done_edge", 64'(done_e), 64'(first_e + exp_s.len()));
    end
  endtask

  initial begin
    int          e;
    int          pct;
    logic [63:0] v;

    i_reset         = 1'b1;
    i_results_valid = 1'b0;
    i_results       = '0;
    i_char_ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_char_valid", 64'(o_char_valid), 64'd0);
    check("rst_char_data", 64'(o_char_data), 64'h00);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    i_reset = 1'b0;

    run_case(64'd600851475143, 100, 1'b0);
    run_case(64'd0, 100, 1'b0);
    run_case(64'hFFFF_FFFF_FFFF_FFFF, 100, 1'b0);
    run_case(64'd4613732, 50, 1'b0);

    // Capture requests during conversion must be dropped, not queued.
    run_case(64'd123, 100, 1'b1);
    run_case(64'd7, 100, 1'b0);

    // Reset while a digit is pending with the sink stalled.
    @(negedge clk);
    i_char_ready    = 1'b0;
    i_results       = 64'd600851475143;
    i_results_valid = 1'b1;
    @(negedge clk);
    i_results_valid = 1'b0;
    e = 0;
    while (!o_char_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    check("emit_reached", 64'(o_char_valid), 64'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check("abort_char_valid", 64'(o_char_valid), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_char_data", 64'(o_char_data), 64'h00);
    i_reset = 1'b0;
    run_case(64'd42, 100, 1'b0);

    for (int k = 0; k < 5; k++) begin
      v   = {$urandom, $urandom} >> $urandom_range(63);
      pct = 30 + int'($urandom_range(70));
      run_case(v, pct, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
